// File: rtl/conf_int_mul_acc_stage.sv
// Saturating multiply-accumulate stage: sums a run of 1..MAX_LEN signed products
// into a wide accumulator and presents the result on a valid/ready port.
module conf_int_mul_acc_stage #(
  parameter int DATA_PATH_BITWIDTH = 32,
  parameter int ACC_BITWIDTH       = 40,
  parameter int MAX_LEN            = 16,
  parameter int LEN_W              = 5
) (
  input  logic                                  clk,
  input  logic                                  racc,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic        [DATA_PATH_BITWIDTH-1:0]  d_in,
  input  logic        [LEN_W-1:0]               len,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic signed [ACC_BITWIDTH-1:0]        acc_out,
  output logic                                  ovf
);

  typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [ACC_BITWIDTH-1:0] ACC_MAX = {1'b0, {(ACC_BITWIDTH-1){1'b1}}};
  localparam logic [ACC_BITWIDTH-1:0] ACC_MIN = {1'b1, {(ACC_BITWIDTH-1){1'b0}}};

  state_t                  state;
  logic [LEN_W-1:0]        count;
  logic [LEN_W-1:0]        run_len;
  logic [LEN_W-1:0]        len_clamped;
  logic [LEN_W-1:0]        count_next;
  logic [ACC_BITWIDTH-1:0] d_ext;
  logic [ACC_BITWIDTH:0]   sum_wide;
  logic [ACC_BITWIDTH-1:0] sum_sat;
  logic                    sum_ovf;

  // One guard bit above the accumulator: the top two bits disagreeing means the
  // true sum left the representable range, and the guard bit gives its sign.
  always_comb begin
    d_ext       = {{(ACC_BITWIDTH-DATA_PATH_BITWIDTH){d_in[DATA_PATH_BITWIDTH-1]}}, d_in};
    sum_wide    = {acc_out[ACC_BITWIDTH-1], acc_out} + {d_ext[ACC_BITWIDTH-1], d_ext};
    sum_ovf     = sum_wide[ACC_BITWIDTH] ^ sum_wide[ACC_BITWIDTH-1];
    sum_sat     = sum_wide[ACC_BITWIDTH-1:0];
    if (sum_ovf) begin
      sum_sat = sum_wide[ACC_BITWIDTH] ? ACC_MIN : ACC_MAX;
    end
    len_clamped = len;
    if (len == '0) begin
      len_clamped = LEN_W'(1);
    end else if (len > MAX_LEN_L) begin
      len_clamped = MAX_LEN_L;
    end
    count_next  = count + LEN_W'(1);
  end

  // Run control; in_ready and out_valid are registered alongside the state so
  // neither has a combinational path from the handshake inputs.
  always_ff @(posedge clk) begin
    if (racc) begin
      state     <= IDLE;
      acc_out   <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      count     <= '0;
      run_len   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            run_len <= len_clamped;
            acc_out <= d_ext;
            ovf     <= 1'b0;
            count   <= LEN_W'(1);
            if (len_clamped == LEN_W'(1)) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc_out <= sum_sat;
            ovf     <= ovf | sum_ovf;
            count   <= count_next;
            if (count_next == run_len) begin
              state     <= HOLD;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            count     <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conf_int_mul_acc_stage.sv
// Scoreboard bench for conf_int_mul_acc_stage: a 40-bit and a 33-bit instance share
// stimulus, and an arithmetic model predicts each run's saturated sum and overflow.
module tb_conf_int_mul_acc_stage;

  typedef struct {
    longint acc;
    bit     ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                racc;
  logic                in_valid;
  logic                in_ready0, in_ready1;
  logic [31:0]         d_in;
  logic [4:0]          len;
  logic                out_valid0, out_valid1;
  logic                out_ready;
  logic signed [39:0]  acc0;
  logic signed [32:0]  acc1;
  logic                ovf0, ovf1;

  int   n_cmp  = 0;
  int   n_fail = 0;
  int   ready_pct = 100;
  exp_t q0[$];
  exp_t q1[$];

  bit     m_active = 1'b0;
  int     m_len, m_count;
  longint m_acc0, m_acc1;
  bit     m_ovf0, m_ovf1;

  always #5 clk = ~clk;

  conf_int_mul_acc_stage #(.ACC_BITWIDTH(40)) dut_wide (
    .clk(clk), .racc(racc), .in_valid(in_valid), .in_ready(in_ready0),
    .d_in(d_in), .len(len), .out_valid(out_valid0), .out_ready(out_ready),
    .acc_out(acc0), .ovf(ovf0)
  );

  conf_int_mul_acc_stage #(.ACC_BITWIDTH(33)) dut_narrow (
    .clk(clk), .racc(racc), .in_valid(in_valid), .in_ready(in_ready1),
    .d_in(d_in), .len(len), .out_valid(out_valid1), .out_ready(out_ready),
    .acc_out(acc1), .ovf(ovf1)
  );

  task automatic checkOutput(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic longint clamp_w(input longint v, input int w);
    longint hi = (longint'(1) <<< (w - 1)) - 1;
    longint lo = -hi - 1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic int clamp_len(input int l);
    if (l == 0) return 1;
    if (l > 16) return 16;
    return l;
  endfunction

  // Reference: a run is the saturating sum of its first L accepted products.
  task automatic model_beat(input int d, input int l);
    longint s;
    exp_t   e;
    if (!m_active) begin
      m_active = 1'b1;
      m_len    = clamp_len(l);
      m_count  = 0;
      m_acc0   = 0;
      m_acc1   = 0;
      m_ovf0   = 1'b0;
      m_ovf1   = 1'b0;
    end
    s = m_acc0 + longint'(d);
    m_acc0 = clamp_w(s, 40);
    m_ovf0 |= (s != m_acc0);
    s = m_acc1 + longint'(d);
    m_acc1 = clamp_w(s, 33);
    m_ovf1 |= (s != m_acc1);
    m_count++;
    if (m_count == m_len) begin
      e.acc = m_acc0; e.ovf = m_ovf0; q0.push_back(e);
      e.acc = m_acc1; e.ovf = m_ovf1; q1.push_back(e);
      m_active = 1'b0;
    end
  endtask

  // Offer one beat and hold it until the stage takes it.
  task automatic applyStimulus(input int d, input int l);
    bit rdy;
    int k = 0;
    @(negedge clk);
    in_valid = 1'b1;
    d_in     = d;
    len      = 5'(l);
    forever begin
      rdy = in_ready0;
      @(posedge clk);
      if (rdy) break;
      k++;
      if (k >= 200) begin
        checkOutput("beat_accept_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    model_beat(d, l);
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  task automatic wait_drain();
    int k = 0;
    while (q0.size() != 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drain_pending", q0.size(), 0);
  endtask

  task automatic applyReset(input int n);
    @(negedge clk);
    racc     = 1'b1;
    in_valid = 1'b1;
    d_in     = 32'd5;
    len      = 5'd0;
    m_active = 1'b0;
    q0.delete();
    q1.delete();
    repeat (n) @(negedge clk);
    racc     = 1'b0;
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    out_ready = ($urandom_range(0, 99) < ready_pct);
  end

  // Monitor: the stage must be holding a result exactly while one is expected.
  always @(negedge clk) begin
    #1;
    if (!racc) begin
      checkOutput("out_valid_wide", out_valid0, longint'(q0.size() != 0));
      checkOutput("out_valid_narrow", out_valid1, longint'(q1.size() != 0));
      checkOutput("in_ready_wide", in_ready0, longint'(q0.size() == 0));
      checkOutput("in_ready_narrow", in_ready1, longint'(q1.size() == 0));
      if (q0.size() != 0 && q1.size() != 0) begin
        checkOutput("acc_wide", longint'(acc0), q0[0].acc);
        checkOutput("ovf_wide", ovf0, longint'(q0[0].ovf));
        checkOutput("acc_narrow", longint'(acc1), q1[0].acc);
        checkOutput("ovf_narrow", ovf1, longint'(q1[0].ovf));
        if (out_ready) begin
          void'(q0.pop_front());
          void'(q1.pop_front());
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int l, nb;
    racc      = 1'b1;
    in_valid  = 1'b1;
    d_in      = 32'd5;
    len       = 5'd0;
    out_ready = 1'b0;

    applyReset(3);
    #1;
    checkOutput("rst_out_valid", out_valid0, 0);
    checkOutput("rst_acc", longint'(acc0), 0);
    checkOutput("rst_ovf", ovf0, 0);
    checkOutput("rst_in_ready", in_ready0, 1);

    $display("[TB] basic run with held output");
    ready_pct = 0;
    applyStimulus(3, 4);
    applyStimulus(-7, 4);
    applyStimulus(100, 4);
    applyStimulus(int'(32'h7FFF_FFF0), 4);
    gap(1);
    repeat (6) @(negedge clk);
    ready_pct = 100;
    wait_drain();

    $display("[TB] gapped run with len change and ignored beat");
    ready_pct = 0;
    applyStimulus(10, 3);
    gap(2);
    applyStimulus(20, 3);
    applyStimulus(30, 9);
    @(negedge clk);
    in_valid = 1'b1;
    d_in     = 32'd999;
    repeat (4) @(negedge clk);
    in_valid  = 1'b0;
    ready_pct = 100;
    wait_drain();

    $display("[TB] edge lengths");
    applyStimulus(-1, 0);
    gap(1);
    wait_drain();
    for (int i = 0; i < 16; i++) applyStimulus(1, 31);
    gap(1);
    wait_drain();

    $display("[TB] saturation");
    for (int i = 0; i < 4; i++) applyStimulus(int'(32'h7FFF_FFFF), 4);
    for (int i = 0; i < 4; i++) applyStimulus(int'(32'h8000_0000), 4);
    applyStimulus(1, 3);
    applyStimulus(2, 3);
    applyStimulus(3, 3);
    gap(1);
    wait_drain();

    $display("[TB] reset mid-run");
    for (int i = 0; i < 5; i++) applyStimulus(1000 + i, 8);
    applyReset(1);
    applyStimulus(7, 2);
    applyStimulus(8, 2);
    gap(1);
    wait_drain();

    $display("[TB] randomized runs");
    for (int r = 0; r < 25; r++) begin
      ready_pct = $urandom_range(20, 100);
      l  = $urandom_range(0, 31);
      nb = clamp_len(l);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 1) == 1)
          applyStimulus(int'($urandom()), (b == 0) ? l : $urandom_range(0, 31));
        else
          applyStimulus($urandom_range(0, 2000) - 1000, (b == 0) ? l : $urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) gap($urandom_range(1, 3));
      end
    end
    gap(1);
    ready_pct = 100;
    wait_drain();
    repeat (3) @(negedge clk);
    checkOutput("final_queue_empty", q1.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
